line_sequencer: RTL
===================

LINE_SEQUENCER -- requirements
Module: line_sequencer

Interface
REQ-001 Parameter NUM_LINES, default 1024, lines per frame in normal mode.
REQ-002 Parameter TEST_LINES, default 4, lines per frame in test mode.
REQ-003 Parameter HBLANK, default 2, blank cycles between lines; legal range 1..15.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port start  input  1  request to begin one frame; honoured only in IDLE.
REQ-007 Port stop  input  1  synchronous abort of the current frame.
REQ-008 Port test  input  1  '1' selects TEST_LINES, '0' selects NUM_LINES; sampled only when a frame starts.
REQ-009 Port end_line  input  1  last-pixel indication from the 12-bit pixel counter.
REQ-010 Port pix_enb  output  1  enable to the pixel counter; active high.
REQ-011 Port line_cnt  output  11  index of the current line, 0-based.
REQ-012 Port busy  output  1  high in every state except IDLE.
REQ-013 Port frame_done  output  1  one-cycle pulse when the last line of a frame completes.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ACTIVE, BLANK and DONE; all outputs SHALL be registered.
REQ-015 IDLE: if start=1 and stop=0, go to ACTIVE, latch test into test_q and clear line_cnt to 0; otherwise stay in IDLE.
REQ-016 ACTIVE: pix_enb=1; end_line=1 on a non-last line SHALL go to BLANK, load the blank counter with HBLANK-1 and increment line_cnt on the same edge.
REQ-017 ACTIVE, last line (line_cnt == TEST_LINES-1 if test_q=1, else NUM_LINES-1): end_line=1 SHALL go to DONE; line_cnt holds.
REQ-018 BLANK: pix_enb=0 for exactly HBLANK cycles; then return to ACTIVE. The first pixel of the next line SHALL see pix_enb=1 HBLANK+1 cycles after the end_line cycle.
REQ-019 DONE: frame_done=1 for exactly one cycle; then go to IDLE unconditionally. A start seen during DONE SHALL be ignored.
REQ-020 end_line SHALL be ignored in IDLE, BLANK and DONE.
REQ-021 start SHALL be ignored in every state except IDLE; a held start SHALL begin a new frame on the first IDLE cycle after DONE.
REQ-022 stop=1 in ACTIVE or BLANK SHALL go to IDLE on the next edge with pix_enb=0 and line_cnt=0; frame_done SHALL stay 0.
REQ-023 stop=1 in DONE SHALL not suppress the frame_done pulse.
REQ-024 stop=1 together with start=1 in IDLE: stop SHALL win and the FSM stays in IDLE.
REQ-025 A change on test during a frame SHALL have no effect until the next start.
REQ-026 line_cnt SHALL never wrap; its maximum value is the last-line index, and NUM_LINES SHALL NOT exceed 2048.

Reset
REQ-027 When rst_n=0 the block SHALL immediately force, regardless of clk: state=IDLE, pix_enb=0, line_cnt=0, busy=0, frame_done=0, test_q=0 and blank counter=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse.
REQ-029 After rst_n deasserts, the first frame SHALL start only on a new start seen in IDLE.

Verification
REQ-030 Setup: test=1, TEST_LINES=4, HBLANK=2, start pulse, end_line driven every 8 pixel-enabled cycles. Required: pix_enb high for 4 bursts separated by exactly 2 low cycles; line_cnt steps 0,1,2,3; frame_done pulses once; the FSM returns to IDLE.
REQ-031 Setup: test=0 with NUM_LINES overridden to 3. Required: 3 lines, then frame_done, then busy=0; toggling test mid-frame leaves the line count at 3.
REQ-032 Setup: stop asserted during BLANK of line 1. Required: next cycle state=IDLE, pix_enb=0, line_cnt=0, no frame_done.
REQ-033 Setup: rst_n pulsed low between clock edges during ACTIVE. Required: outputs clear asynchronously; a later start runs a complete frame.
REQ-034 Setup: start held high continuously. Required: back-to-back frames, one IDLE cycle between DONE and the next ACTIVE.
REQ-035 Setup: end_line asserted in IDLE, in BLANK, and with start+stop together in IDLE. Required: line_cnt unchanged and the FSM remains in its state.

Source files
------------

// File: rtl/line_sequencer.sv
// Line sequencer: steps a frame of lines through ACTIVE/BLANK phases, gating the
// pixel counter and reporting line index, busy and a one-cycle end-of-frame pulse.
module line_sequencer #(
    parameter int NUM_LINES  = 1024,
    parameter int TEST_LINES = 4,
    parameter int HBLANK     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        test,
    input  logic        end_line,
    output logic        pix_enb,
    output logic [10:0] line_cnt,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_BLANK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [10:0] NORM_LAST  = 11'(NUM_LINES - 1);
    localparam logic [10:0] TEST_LAST  = 11'(TEST_LINES - 1);
    localparam logic [3:0]  BLANK_LOAD = 4'(HBLANK - 1);

    logic [1:0]  state_r;
    logic [1:0]  state_s;
    logic [10:0] line_r;
    logic [10:0] line_s;
    logic [3:0]  blank_r;
    logic [3:0]  blank_s;
    logic        test_r;
    logic        test_s;
    logic [10:0] last_s;
    logic        pix_enb_r;
    logic        busy_r;
    logic        frame_done_r;

    // Last-line index for the mode latched at frame start
    always_comb begin
        if (test_r) begin
            last_s = TEST_LAST;
        end else begin
            last_s = NORM_LAST;
        end
    end

    // Next-state and datapath decode; stop beats everything except a pending DONE
    always_comb begin
        state_s = state_r;
        line_s  = line_r;
        blank_s = blank_r;
        test_s  = test_r;
        case (state_r)
            S_IDLE: begin
                if (start && !stop) begin
                    state_s = S_ACTIVE;
                    test_s  = test;
                    line_s  = 11'd0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (stop) begin
                    state_s = S_IDLE;
                    line_s  = 11'd0;
                    blank_s = 4'd0;
                end else if (end_line) begin
                    if (line_r == last_s) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_BLANK;
                        blank_s = BLANK_LOAD;
                        line_s  = line_r + 11'd1;
                    end
                end else begin
                    state_s = S_ACTIVE;
                end
            end
            S_BLANK: begin
                if (stop) begin
                    state_s = S_IDLE;
                    line_s  = 11'd0;
                    blank_s = 4'd0;
                end else if (blank_r == 4'd0) begin
                    state_s = S_ACTIVE;
                end else begin
                    blank_s = blank_r - 4'd1;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                line_s  = 11'd0;
                blank_s = 4'd0;
            end
        endcase
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            line_r       <= 11'd0;
            blank_r      <= 4'd0;
            test_r       <= 1'b0;
            pix_enb_r    <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            line_r       <= line_s;
            blank_r      <= blank_s;
            test_r       <= test_s;
            pix_enb_r    <= (state_s == S_ACTIVE);
            busy_r       <= (state_s != S_IDLE);
            frame_done_r <= (state_s == S_DONE);
        end
    end

    assign pix_enb    = pix_enb_r;
    assign line_cnt   = line_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule
